// File: rtl/ts_tx_gen.sv
// MPEG-TS test-stream source: continuous 188-byte packets with a programmable PID,
// a rolling continuity counter and a counting payload on a DATA/DCLK/D_VALID/P_SYNC port.
module ts_tx_gen #(
    parameter int CLK_DIV   = 4,
    parameter int GAP_BYTES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [12:0] PID,
    output logic [7:0]  DATA,
    output logic        DCLK,
    output logic        D_VALID,
    output logic        P_SYNC,
    output logic        PKT_DONE,
    output logic [2:0]  dbg_state
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_BYTES - 1);
    localparam logic [7:0]      LAST_IDX = 8'd187;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       byte_idx;
    logic [7:0]       gap_cnt;
    logic [7:0]       payload_cnt;
    logic [3:0]       cc;
    logic [12:0]      pid_q;
    logic             byte_tick;
    logic             start_slot;

    assign byte_tick = (div_cnt == DIV_LAST);
    assign dbg_state = state;

    // Slots where a new packet may begin; EN is only looked at here.
    assign start_slot = (state == IDLE)
                     || (state == GAP && gap_cnt == GAP_LAST)
                     || (state == PAYLOAD && byte_idx == LAST_IDX && GAP_BYTES == 0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            div_cnt     <= '0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            payload_cnt <= '0;
            cc          <= '0;
            pid_q       <= '0;
            DATA        <= '0;
            DCLK        <= 1'b0;
            D_VALID     <= 1'b0;
            P_SYNC      <= 1'b0;
            PKT_DONE    <= 1'b0;
        end else begin
            PKT_DONE <= 1'b0;
            div_cnt  <= byte_tick ? '0 : div_cnt + DIV_W'(1);

            if (byte_tick) begin
                DCLK <= 1'b0;
            end else if (div_cnt == DIV_HALF) begin
                DCLK <= 1'b1;
            end

            if (byte_tick) begin
                if (start_slot) begin
                    byte_idx <= '0;
                    gap_cnt  <= '0;
                    if (EN) begin
                        state   <= SYNC;
                        pid_q   <= PID;
                        DATA    <= 8'h47;
                        P_SYNC  <= 1'b1;
                        D_VALID <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        DATA    <= 8'h00;
                        P_SYNC  <= 1'b0;
                        D_VALID <= 1'b0;
                    end
                end else begin
                    case (state)
                        SYNC: begin
                            state    <= HDR;
                            byte_idx <= 8'd1;
                            P_SYNC   <= 1'b0;
                            DATA     <= {3'b010, pid_q[12:8]};
                        end
                        HDR: begin
                            byte_idx <= byte_idx + 8'd1;
                            if (byte_idx == 8'd1) begin
                                DATA <= pid_q[7:0];
                            end else if (byte_idx == 8'd2) begin
                                DATA <= {4'b0001, cc};
                            end else begin
                                state       <= PAYLOAD;
                                DATA        <= payload_cnt;
                                payload_cnt <= payload_cnt + 8'd1;
                            end
                        end
                        PAYLOAD: begin
                            if (byte_idx != LAST_IDX) begin
                                byte_idx    <= byte_idx + 8'd1;
                                DATA        <= payload_cnt;
                                payload_cnt <= payload_cnt + 8'd1;
                                // The pulse and cc step mark the edge that drives byte 187.
                                if (byte_idx == LAST_IDX - 8'd1) begin
                                    PKT_DONE <= 1'b1;
                                    cc       <= cc + 4'd1;
                                end
                            end else begin
                                state    <= GAP;
                                byte_idx <= '0;
                                gap_cnt  <= '0;
                                DATA     <= 8'h00;
                                D_VALID  <= 1'b0;
                            end
                        end
                        GAP: begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_tx_gen.sv
// Directed bench for ts_tx_gen: one instance without gaps (reset, continuous run,
// EN handling) and one with a 3-byte gap (latency, PID change, reset mid-packet).
module tb_ts_tx_gen;

  localparam int DIV = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst0, rst1, en0, en1;
  logic [12:0] pid0, pid1;
  logic [7:0]  data0, data1;
  logic        dclk0, dclk1, dv0, dv1, ps0, ps1, done0, done1;
  logic [2:0]  st0, st1;

  ts_tx_gen #(.CLK_DIV(DIV), .GAP_BYTES(0)) dut0 (
    .CLK(CLK), .RST(rst0), .EN(en0), .PID(pid0),
    .DATA(data0), .DCLK(dclk0), .D_VALID(dv0), .P_SYNC(ps0),
    .PKT_DONE(done0), .dbg_state(st0)
  );

  ts_tx_gen #(.CLK_DIV(DIV), .GAP_BYTES(3)) dut1 (
    .CLK(CLK), .RST(rst1), .EN(en1), .PID(pid1),
    .DATA(data1), .DCLK(dclk1), .D_VALID(dv1), .P_SYNC(ps1),
    .PKT_DONE(done1), .dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int exp_done [2];
  logic [9:0] exp_q[$];

  always @(negedge CLK) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  typedef struct {
    logic [12:0] pid;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  p0;
    logic        drop_en;
  } vec_t;

  vec_t tbl [18];

  // ---------------- helpers / driver tasks ----------------
  function automatic logic cur_dclk(input int sel);
    return (sel == 0) ? dclk0 : dclk1;
  endfunction

  function automatic logic [9:0] cur_bits(input int sel);
    return (sel == 0) ? {dv0, ps0, data0} : {dv1, ps1, data1};
  endfunction

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en0 = v; else en1 = v;
  endtask

  task automatic set_pid(input int sel, input logic [12:0] v);
    if (sel == 0) pid0 = v; else pid1 = v;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the next DCLK rising edge and return {D_VALID, P_SYNC, DATA}.
  task automatic next_byte(input int sel, output logic [9:0] got, output bit ok);
    logic prev;
    prev = cur_dclk(sel);
    ok   = 1'b0;
    got  = '0;
    for (int i = 0; i < 4 * DIV && !ok; i++) begin
      @(negedge CLK);
      if (!prev && cur_dclk(sel)) begin
        ok  = 1'b1;
        got = cur_bits(sel);
      end
      prev = cur_dclk(sel);
    end
  endtask

  task automatic check_byte(input int sel, input string name, input logic [9:0] exp);
    logic [9:0] got;
    bit ok;
    next_byte(sel, got, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no DCLK rise within %0d cycles, expected %h", name, 4 * DIV, exp);
    end else begin
      check(name, 16'(got), 16'(exp));
    end
  endtask

  // Check bytes 0..last of a packet; optional PID change / EN drop after given bytes.
  task automatic check_packet(input int sel, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] p0, input int last,
                              input int pid_at, input logic [12:0] new_pid, input int en_off_at);
    logic [7:0] p;
    logic [9:0] exp;
    int dc;
    p = p0;
    exp_q.delete();
    exp_q.push_back({2'b11, 8'h47});
    exp_q.push_back({2'b10, b1});
    exp_q.push_back({2'b10, b2});
    exp_q.push_back({2'b10, b3});
    for (int i = 4; i <= last; i++) begin
      exp_q.push_back({2'b10, p});
      p = p + 8'd1;
    end
    for (int i = 0; i <= last; i++) begin
      exp = exp_q.pop_front();
      check_byte(sel, $sformatf("dut%0d_byte%0d", sel, i), exp);
      if (i == pid_at) set_pid(sel, new_pid);
      if (i == en_off_at) set_en(sel, 1'b0);
    end
    if (last == 187) begin
      exp_done[sel]++;
      dc = (sel == 0) ? done_cnt0 : done_cnt1;
      checks++;
      if (dc != exp_done[sel]) begin
        errors++;
        $display("FAIL dut%0d_pkt_done_count: got %0d expected %0d", sel, dc, exp_done[sel]);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rises, highs, dvs;
    logic prev;

    tbl[0]  = '{13'h01FF, 8'h41, 8'hFF, 8'h10, 8'h00, 1'b0};
    tbl[1]  = '{13'h0000, 8'h40, 8'h00, 8'h11, 8'hB8, 1'b0};
    tbl[2]  = '{13'h1FFF, 8'h5F, 8'hFF, 8'h12, 8'h70, 1'b0};
    tbl[3]  = '{13'h1234, 8'h52, 8'h34, 8'h13, 8'h28, 1'b0};
    tbl[4]  = '{13'h0100, 8'h41, 8'h00, 8'h14, 8'hE0, 1'b0};
    tbl[5]  = '{13'h0ABC, 8'h4A, 8'hBC, 8'h15, 8'h98, 1'b0};
    tbl[6]  = '{13'h1000, 8'h50, 8'h00, 8'h16, 8'h50, 1'b0};
    tbl[7]  = '{13'h00FF, 8'h40, 8'hFF, 8'h17, 8'h08, 1'b0};
    tbl[8]  = '{13'h0811, 8'h48, 8'h11, 8'h18, 8'hC0, 1'b0};
    tbl[9]  = '{13'h1555, 8'h55, 8'h55, 8'h19, 8'h78, 1'b0};
    tbl[10] = '{13'h0AAA, 8'h4A, 8'hAA, 8'h1A, 8'h30, 1'b0};
    tbl[11] = '{13'h0042, 8'h40, 8'h42, 8'h1B, 8'hE8, 1'b0};
    tbl[12] = '{13'h1F00, 8'h5F, 8'h00, 8'h1C, 8'hA0, 1'b0};
    tbl[13] = '{13'h0001, 8'h40, 8'h01, 8'h1D, 8'h58, 1'b0};
    tbl[14] = '{13'h0FFF, 8'h4F, 8'hFF, 8'h1E, 8'h10, 1'b0};
    tbl[15] = '{13'h1001, 8'h50, 8'h01, 8'h1F, 8'hC8, 1'b0};
    tbl[16] = '{13'h0123, 8'h41, 8'h23, 8'h10, 8'h80, 1'b1};
    tbl[17] = '{13'h0123, 8'h41, 8'h23, 8'h11, 8'h38, 1'b0};
    exp_done[0] = 0;
    exp_done[1] = 0;

    rst0 = 1'b1; en0 = 1'b0; pid0 = tbl[0].pid;
    rst1 = 1'b0; en1 = 1'b1; pid1 = 13'h0ABC;

    // Reset state of the gapless instance.
    #2 rst0 = 1'b0;
    #1 check("dut0_reset_async", {2'b00, st0, done0, dclk0, dv0, ps0, data0}, 16'h0000);
    repeat (3) @(negedge CLK);
    check("dut0_reset_hold", {2'b00, st0, done0, dclk0, dv0, ps0, data0}, 16'h0000);

    // 1000 idle cycles: DCLK keeps its period, nothing is valid.
    rst0 = 1'b1;
    rises = 0; highs = 0; dvs = 0; prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (dclk0 && !prev) rises++;
      if (dclk0) highs++;
      if (dv0 || data0 != 8'h00) dvs++;
      prev = dclk0;
    end
    check("dut0_idle_dclk_rises", 16'(rises), 16'd250);
    check("dut0_idle_dclk_high", 16'(highs), 16'd500);
    check("dut0_idle_valid", 16'(dvs), 16'd0);

    // Continuous run, PID per packet, EN dropped at byte 100 of packet 16.
    en0 = 1'b1;
    check_byte(0, "dut0_pre_sync_idle", 10'h000);
    for (int k = 0; k < 18; k++) begin
      check_packet(0, tbl[k].b1, tbl[k].b2, tbl[k].b3, tbl[k].p0, 187,
                   3, tbl[(k < 17) ? k + 1 : k].pid, tbl[k].drop_en ? 100 : -1);
      if (tbl[k].drop_en) begin
        for (int j = 0; j < 4; j++) begin
          check_byte(0, $sformatf("dut0_idle%0d", j), 10'h000);
          if (j == 1) begin
            en0 = 1'b1;
            @(negedge CLK);
            en0 = 1'b0;
          end
        end
        en0 = 1'b1;
      end
    end

    // Gap instance: first-byte latency after reset release with EN=1.
    @(negedge CLK);
    rst1 = 1'b1;
    repeat (3) @(negedge CLK);
    check("dut1_latency_before", {5'b0, dclk1, dv1, ps1, data1}, 16'h0400);
    @(negedge CLK);
    check("dut1_latency_sync", {5'b0, dclk1, dv1, ps1, data1}, 16'h0347);

    check_packet(1, 8'h4A, 8'hBC, 8'h10, 8'h00, 187, 50, 13'h0100, -1);
    for (int j = 0; j < 3; j++) check_byte(1, $sformatf("dut1_gap%0d", j), 10'h000);
    check_packet(1, 8'h41, 8'h00, 8'h11, 8'hB8, 120, -1, 13'h0000, -1);

    // Reset in the middle of a packet.
    #1 rst1 = 1'b0;
    pid1 = 13'h01FF;
    #1 check("dut1_reset_mid", {2'b00, st1, done1, dclk1, dv1, ps1, data1}, 16'h0000);
    repeat (2) @(negedge CLK);
    rst1 = 1'b1;
    check_byte(1, "dut1_pre_sync_idle", 10'h000);
    check_packet(1, 8'h41, 8'hFF, 8'h10, 8'h00, 187, -1, 13'h0000, -1);
    for (int j = 0; j < 3; j++) check_byte(1, $sformatf("dut1_gap_b%0d", j), 10'h000);
    check_packet(1, 8'h41, 8'hFF, 8'h11, 8'hB8, 20, -1, 13'h0000, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ts_tx_gen.md
# ts_tx_gen

Parallel MPEG-TS test-stream transmitter that drives the same DATA/DCLK/D_VALID/P_SYNC interface the muxer's input channels receive. It generates continuous 188-byte transport packets with a programmable PID, a rolling continuity counter and a counting payload. It is used as an on-board loopback source for any tuner channel input and as the stimulus generator for channel-switch tests.

## Interface
- CLK_DIV, 4: CLK cycles per transmitted byte. Even, ≥2.
- GAP_BYTES, 0: idle byte slots (D_VALID=0) inserted between packets. Range 0–255.
- CLK  in  1  system clock (sys_clk domain).
- RST  in  1  reset. Asynchronous, active-low.
- EN  in  1  generation enable. Sampled only at packet boundaries.
- PID  in  13  PID for the next packet. Latched at the sync-byte slot.
- DATA  out  8  TS byte.
- DCLK  out  1  byte clock. The receiver samples on its rising edge.
- D_VALID  out  1  high for all 188 bytes of a packet.
- P_SYNC  out  1  high only during byte 0 (0x47).
- PKT_DONE  out  1  one-CLK pulse when byte 187 is driven.

## Operation
- **Divider.** div_cnt free-runs 0..CLK_DIV-1.
  - byte_tick = (div_cnt == CLK_DIV-1).
  - All byte outputs update only on the byte_tick edge.
- **States:** IDLE, SYNC, HDR, PAYLOAD, GAP. byte_idx counts 0..187.
- **IDLE.** On byte_tick with EN=1, go to SYNC: DATA=0x47, P_SYNC=1, D_VALID=1, latch PID. With EN=0, hold DATA=0 and D_VALID=0.
- **HDR.** Bytes 1–3:
  - byte1 = {1'b0 TEI, 1'b1 PUSI, 1'b0 prio, PID[12:8]}
  - byte2 = PID[7:0]
  - byte3 = {2'b00, 2'b01, cc[3:0]}
- **PAYLOAD.** Bytes 4–187 = payload_cnt. payload_cnt increments per payload byte, 8-bit wrap 0xFF→0x00, and carries across packets.
- **Packet end.** On byte 187, pulse PKT_DONE. cc increments mod 16 once the packet completes.
- **After byte 187:**
  - GAP_BYTES>0: enter GAP for GAP_BYTES byte slots with D_VALID=0, P_SYNC=0, DATA=0x00.
  - At the end of the gap, or immediately if GAP_BYTES=0: EN=1 starts SYNC in the next slot (back-to-back when the gap is 0). EN=0 goes to IDLE.
- **EN deasserted mid-packet.** The current packet completes to byte 187. Packets are never truncated.
- **PID change mid-packet.** Ignored until the next SYNC.
- **Reset (any time, including mid-packet):**
  - DATA=0x00, D_VALID=0, P_SYNC=0, DCLK=0, PKT_DONE=0
  - div_cnt=0, byte_idx=0, cc=0, payload_cnt=0, state IDLE
  - The partial packet is abandoned.

## Timing
- **DCLK generation.** DCLK is a register, cleared on the byte_tick edge and set on the edge where div_cnt==CLK_DIV/2-1.
  - DCLK is low for CLK_DIV/2 cycles after each byte update, then high for CLK_DIV/2 cycles.
  - The DCLK rising edge is CLK_DIV/2 CLK cycles after the data change. Data is held CLK_DIV/2 cycles past it.
- **Clock continuity.** DCLK toggles continuously out of reset, including in IDLE and GAP.
- **First byte latency.** After RST release with EN=1, the first sync byte appears on the first byte_tick edge (CLK_DIV CLK edges after release).
- **Packet period.** (188+GAP_BYTES)·CLK_DIV CLK cycles.
- **PKT_DONE.** High for exactly the CLK cycle following the edge that drives byte 187.
- **EN sampling.** EN is sampled only on the byte_tick where the next packet would start. EN pulses between ticks are ignored.

## Test plan
- **Reset.** Hold RST=0 → all outputs 0. Release with EN=0 for 1000 cycles → D_VALID stays 0 and DCLK toggles with period CLK_DIV.
- **Single packet.** EN=1, PID=0x1FF, CLK_DIV=4 → sampled on DCLK rise: 0x47 (P_SYNC=1), 0x41, 0xFF, 0x10, then 0x00..0xB7. D_VALID high 188 bytes, PKT_DONE one pulse.
- **Continuous run.** GAP_BYTES=0, EN held 17 packets:
  - Packets are back-to-back.
  - cc runs 0..15, 0.
  - Packet 1 payload starts 0xB8.
  - payload_cnt wraps 0xFF→0x00 inside packet 1.
- **Gap and PID change.** GAP_BYTES=3. Change PID to 0x0100 at byte 50 → current packet keeps the old PID. Next packet carries byte1=0x41, byte2=0x00. Exactly 3 byte slots with D_VALID=0 between packets.
- **EN mid-packet.** Drop EN at byte 100 → packet finishes through byte 187, then IDLE. Raise EN again → next packet uses the next cc value.
- **Reset mid-packet.** Assert RST at byte 120 → outputs clear asynchronously. After release with EN=1, the packet restarts at 0x47 with cc=0 and payload 0x00.
